mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between the IF stage (instruction fetch) and the MEM stage (lw/sw) of the pipelined CPU.
- Grants one access at a time and drives the memory handshake, including variable-latency (Mem_Rdy) memory.
- Returns read data and a one-cycle ack to each requester, and produces per-stage stall signals for the pipeline control logic.

---
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and data access.
// Alternating priority when both stages wait; handles variable-latency memory with a timeout.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              If_Req,
  input  logic [ADDR_W-1:0] If_Addr,
  output logic [DATA_W-1:0] If_Rdata,
  output logic              If_Ack,
  input  logic              Dm_Req,
  input  logic              Dm_Wmem,
  input  logic [ADDR_W-1:0] Dm_Addr,
  input  logic [DATA_W-1:0] Dm_Wdata,
  output logic [DATA_W-1:0] Dm_Rdata,
  output logic              Dm_Ack,
  output logic              Mem_Cs,
  output logic              Mem_We,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_Wdata,
  input  logic [DATA_W-1:0] Mem_Rdata,
  input  logic              Mem_Rdy,
  output logic              Stall_If,
  output logic              Stall_Mem,
  output logic              Timeout
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_ACC = 2'd1,
    DM_ACC = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             last_dm;
  logic             if_elig, dm_elig;
  logic             grant_if, grant_dm;
  logic             in_acc, expire, done;

  // A requester still holding Req during its own Ack cycle is not re-granted.
  always_comb begin
    if_elig  = If_Req & ~If_Ack;
    dm_elig  = Dm_Req & ~Dm_Ack;
    grant_dm = (state == IDLE) & dm_elig & (~if_elig | ~last_dm);
    grant_if = (state == IDLE) & if_elig & ~grant_dm;
    in_acc   = (state != IDLE);
    expire   = in_acc & ~Mem_Rdy & (wait_cnt == CNT_W'(MAX_WAIT - 1));
    done     = in_acc & (Mem_Rdy | expire);
  end

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_dm)      state_nxt = DM_ACC;
        else if (grant_if) state_nxt = IF_ACC;
      end
      IF_ACC, DM_ACC: if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Mem_Cs    = in_acc;
    Stall_If  = If_Req & ~If_Ack;
    Stall_Mem = Dm_Req & ~Dm_Ack;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      Mem_We    <= 1'b0;
      Mem_Addr  <= '0;
      Mem_Wdata <= '0;
      If_Rdata  <= '0;
      Dm_Rdata  <= '0;
      If_Ack    <= 1'b0;
      Dm_Ack    <= 1'b0;
      Timeout   <= 1'b0;
      wait_cnt  <= '0;
      last_dm   <= 1'b0;
    end else begin
      If_Ack <= done & (state == IF_ACC);
      Dm_Ack <= done & (state == DM_ACC);

      if (grant_dm) begin
        Mem_Addr  <= Dm_Addr;
        Mem_We    <= Dm_Wmem;
        Mem_Wdata <= Dm_Wdata;
        wait_cnt  <= '0;
        last_dm   <= 1'b1;
      end else if (grant_if) begin
        Mem_Addr  <= If_Addr;
        Mem_We    <= 1'b0;
        Mem_Wdata <= '0;
        wait_cnt  <= '0;
        last_dm   <= 1'b0;
      end else if (in_acc & ~Mem_Rdy) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end

      // A timed-out access completes like a normal one but returns zero data.
      if (done) begin
        Mem_We <= 1'b0;
        if (state == IF_ACC) If_Rdata <= Mem_Rdy ? Mem_Rdata : '0;
        else                 Dm_Rdata <= Mem_Rdy ? Mem_Rdata : '0;
        if (expire) Timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter: memory model with programmable wait states,
// expected completions queued at stimulus time and compared when the Acks appear.
module tb_mem_port_arbiter;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        If_Req, Dm_Req, Dm_Wmem;
  logic [31:0] If_Addr, Dm_Addr, Dm_Wdata;
  logic [31:0] If_Rdata, Dm_Rdata, Mem_Addr, Mem_Wdata, Mem_Rdata;
  logic        If_Ack, Dm_Ack, Mem_Cs, Mem_We, Mem_Rdy;
  logic        Stall_If, Stall_Mem, Timeout;

  typedef struct {
    bit          dm;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  int          wait_n   = 0;
  bit          stuck    = 1'b0;
  int          acc_cnt  = 0;
  int          wr_cnt   = 0;
  logic [31:0] wr_addr  = '0;
  logic [31:0] wr_data  = '0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15)) dut (
    .Clk(Clk), .Rst(Rst),
    .If_Req(If_Req), .If_Addr(If_Addr), .If_Rdata(If_Rdata), .If_Ack(If_Ack),
    .Dm_Req(Dm_Req), .Dm_Wmem(Dm_Wmem), .Dm_Addr(Dm_Addr), .Dm_Wdata(Dm_Wdata),
    .Dm_Rdata(Dm_Rdata), .Dm_Ack(Dm_Ack),
    .Mem_Cs(Mem_Cs), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr), .Mem_Wdata(Mem_Wdata),
    .Mem_Rdata(Mem_Rdata), .Mem_Rdy(Mem_Rdy),
    .Stall_If(Stall_If), .Stall_Mem(Stall_Mem), .Timeout(Timeout)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C01_0004;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory model: ready after wait_n stalled cycles of chip select, never when stuck.
  assign Mem_Rdata = mem_word(Mem_Addr);
  assign Mem_Rdy   = Mem_Cs && !stuck && (acc_cnt >= wait_n);

  always @(posedge Clk) begin
    if (Mem_Cs && !Mem_Rdy) acc_cnt <= acc_cnt + 1;
    else                    acc_cnt <= 0;
    if (Mem_Cs && Mem_We && Mem_Rdy) begin
      wr_addr <= Mem_Addr;
      wr_data <= Mem_Wdata;
      wr_cnt  <= wr_cnt + 1;
    end
  end

  // Steps to the first cycle showing an Ack (or until budget), counting chip-select cycles.
  task automatic wait_ack(input int budget, output int cs_cycles);
    cs_cycles = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      if (If_Ack || Dm_Ack) return;
      if (Mem_Cs) cs_cycles++;
    end
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1; If_Req = 1'b0; Dm_Req = 1'b0; Dm_Wmem = 1'b0;
    If_Addr = '0; Dm_Addr = '0; Dm_Wdata = '0;
    repeat (3) @(negedge Clk);
    chk_cnt++;
    if ({Mem_Cs, Mem_We, If_Ack, Dm_Ack, Timeout, Stall_If, Stall_Mem} !== 7'b0)
      $display("FAIL reset_ctl: got %b want 0000000",
               {Mem_Cs, Mem_We, If_Ack, Dm_Ack, Timeout, Stall_If, Stall_Mem});
    else pass_cnt++;
    chk_cnt++;
    if ({Mem_Addr, Mem_Wdata, If_Rdata, Dm_Rdata} !== 128'b0)
      $display("FAIL reset_data: got %h %h %h %h want all 0", Mem_Addr, Mem_Wdata, If_Rdata, Dm_Rdata);
    else pass_cnt++;
    Rst = 1'b0;
  endtask

  task automatic test_fetch();
    exp_t e;
    wait_n = 0; stuck = 1'b0;
    @(negedge Clk);
    If_Addr = 32'h40; If_Req = 1'b1;
    sb.push_back('{1'b0, 32'h8C01_0004});
    #1;
    chk_cnt++;
    if (Stall_If !== 1'b1) $display("FAIL fetch_stall_t: got %b want 1", Stall_If);
    else pass_cnt++;
    @(negedge Clk);
    chk_cnt++;
    if ({Mem_Cs, Mem_We, If_Ack, Stall_If, Mem_Addr} !== {4'b1001, 32'h40})
      $display("FAIL fetch_grant: got cs/we/ack/stall=%b addr=%h want 1001 addr=00000040",
               {Mem_Cs, Mem_We, If_Ack, Stall_If}, Mem_Addr);
    else pass_cnt++;
    @(negedge Clk);
    e = sb.pop_front();
    chk_cnt++;
    if ({If_Ack, Dm_Ack, Stall_If, If_Rdata} !== {3'b100, e.data})
      $display("FAIL fetch_ack: got ack_if/ack_dm/stall=%b rdata=%h want 100 rdata=%h",
               {If_Ack, Dm_Ack, Stall_If}, If_Rdata, e.data);
    else pass_cnt++;
    If_Req = 1'b0;
    @(negedge Clk);
    chk_cnt++;
    if ({If_Ack, Mem_Cs} !== 2'b00) $display("FAIL fetch_after: got ack/cs=%b want 00", {If_Ack, Mem_Cs});
    else pass_cnt++;
  endtask

  task automatic test_store_wait();
    exp_t e;
    int   wr0;
    wait_n = 3;
    wr0 = wr_cnt;
    @(negedge Clk);
    Dm_Req = 1'b1; Dm_Wmem = 1'b1; Dm_Addr = 32'h100; Dm_Wdata = 32'hDEAD_BEEF;
    sb.push_back('{1'b1, mem_word(32'h100)});
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      chk_cnt++;
      if ({Mem_Cs, Mem_We, Dm_Ack, If_Ack, Mem_Addr, Mem_Wdata} !== {4'b1100, 32'h100, 32'hDEAD_BEEF})
        $display("FAIL store_hold[%0d]: got cs/we/ack=%b addr=%h wdata=%h want 1100 00000100 deadbeef",
                 i, {Mem_Cs, Mem_We, Dm_Ack, If_Ack}, Mem_Addr, Mem_Wdata);
      else pass_cnt++;
    end
    @(negedge Clk);
    e = sb.pop_front();
    chk_cnt++;
    if ({Dm_Ack, If_Ack, Mem_Cs, Mem_We, Dm_Rdata} !== {4'b1000, e.data})
      $display("FAIL store_ack: got ack_dm/ack_if/cs/we=%b rdata=%h want 1000 rdata=%h",
               {Dm_Ack, If_Ack, Mem_Cs, Mem_We}, Dm_Rdata, e.data);
    else pass_cnt++;
    chk_cnt++;
    if ({wr_cnt - wr0, wr_addr, wr_data} !== {32'd1, 32'h100, 32'hDEAD_BEEF})
      $display("FAIL store_write: got n=%0d addr=%h data=%h want n=1 00000100 deadbeef",
               wr_cnt - wr0, wr_addr, wr_data);
    else pass_cnt++;
    Dm_Req = 1'b0; Dm_Wmem = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_alternation();
    exp_t        e;
    logic [31:0] exp_addr;
    logic [1:0]  exp_ack;
    do_reset();
    wait_n = 0;
    @(negedge Clk);
    If_Addr = 32'h200; Dm_Addr = 32'h300; Dm_Wmem = 1'b0;
    If_Req = 1'b1; Dm_Req = 1'b1;
    sb.push_back('{1'b1, mem_word(32'h300)});
    sb.push_back('{1'b0, mem_word(32'h200)});
    sb.push_back('{1'b1, mem_word(32'h300)});
    for (int k = 0; k < 6; k++) begin
      @(negedge Clk);
      if (k % 2 == 0) begin
        exp_addr = (k == 2) ? 32'h200 : 32'h300;
        chk_cnt++;
        if ({Mem_Cs, If_Ack, Dm_Ack, Mem_Addr} !== {3'b100, exp_addr})
          $display("FAIL alt_grant[%0d]: got cs/ackif/ackdm=%b addr=%h want 100 addr=%h",
                   k, {Mem_Cs, If_Ack, Dm_Ack}, Mem_Addr, exp_addr);
        else pass_cnt++;
      end else begin
        e = sb.pop_front();
        exp_ack = e.dm ? 2'b01 : 2'b10;
        chk_cnt++;
        if ({Mem_Cs, If_Ack, Dm_Ack} !== {1'b0, exp_ack} || (e.dm ? Dm_Rdata : If_Rdata) !== e.data)
          $display("FAIL alt_ack[%0d]: got cs/ackif/ackdm=%b rdata=%h want 0%b rdata=%h",
                   k, {Mem_Cs, If_Ack, Dm_Ack}, e.dm ? Dm_Rdata : If_Rdata, exp_ack, e.data);
        else pass_cnt++;
      end
    end
    If_Req = 1'b0; Dm_Req = 1'b0;
    @(negedge Clk);
    chk_cnt++;
    if ({Mem_Cs, If_Ack, Dm_Ack} !== 3'b000)
      $display("FAIL alt_end: got cs/ackif/ackdm=%b want 000", {Mem_Cs, If_Ack, Dm_Ack});
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    exp_t e;
    int   cs_n;
    wait_n = 0; stuck = 1'b1;
    @(negedge Clk);
    chk_cnt++;
    if (Timeout !== 1'b0) $display("FAIL timeout_pre: got %b want 0", Timeout);
    else pass_cnt++;
    If_Addr = 32'h80; If_Req = 1'b1;
    sb.push_back('{1'b0, 32'h0});
    wait_ack(40, cs_n);
    e = sb.pop_front();
    chk_cnt++;
    if ({If_Ack, Dm_Ack, Timeout} !== 3'b101 || If_Rdata !== e.data || cs_n != 15)
      $display("FAIL timeout_ack: got ack/ackdm/to=%b rdata=%h cs_cycles=%0d want 101 rdata=%h cs_cycles=15",
               {If_Ack, Dm_Ack, Timeout}, If_Rdata, cs_n, e.data);
    else pass_cnt++;
    If_Req = 1'b0; stuck = 1'b0;
    @(negedge Clk);
    If_Addr = 32'h84; If_Req = 1'b1;
    sb.push_back('{1'b0, mem_word(32'h84)});
    wait_ack(10, cs_n);
    e = sb.pop_front();
    chk_cnt++;
    if ({If_Ack, Timeout} !== 2'b11 || If_Rdata !== e.data || cs_n != 1)
      $display("FAIL timeout_sticky: got ack/to=%b rdata=%h cs_cycles=%0d want 11 rdata=%h cs_cycles=1",
               {If_Ack, Timeout}, If_Rdata, cs_n, e.data);
    else pass_cnt++;
    If_Req = 1'b0;
    do_reset();
    chk_cnt++;
    if (Timeout !== 1'b0) $display("FAIL timeout_clear: got %b want 0", Timeout);
    else pass_cnt++;
  endtask

  task automatic test_rst_mid();
    exp_t e;
    int   cs_n;
    wait_n = 5;
    @(negedge Clk);
    Dm_Addr = 32'h180; Dm_Wmem = 1'b0; Dm_Req = 1'b1;
    sb.push_back('{1'b1, mem_word(32'h180)});
    @(negedge Clk);
    chk_cnt++;
    if (Mem_Cs !== 1'b1) $display("FAIL rst_mid_grant: got cs=%b want 1", Mem_Cs);
    else pass_cnt++;
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    chk_cnt++;
    if ({Mem_Cs, Dm_Ack, If_Ack} !== 3'b000)
      $display("FAIL rst_mid_abort: got cs/ackdm/ackif=%b want 000", {Mem_Cs, Dm_Ack, If_Ack});
    else pass_cnt++;
    Rst = 1'b0;
    wait_ack(20, cs_n);
    e = sb.pop_front();
    chk_cnt++;
    if ({Dm_Ack, If_Ack} !== 2'b10 || Dm_Rdata !== e.data || cs_n != 6)
      $display("FAIL rst_mid_reissue: got ackdm/ackif=%b rdata=%h cs_cycles=%0d want 10 rdata=%h cs_cycles=6",
               {Dm_Ack, If_Ack}, Dm_Rdata, cs_n, e.data);
    else pass_cnt++;
    Dm_Req = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_ack_mask();
    exp_t e;
    wait_n = 0;
    @(negedge Clk);
    Dm_Addr = 32'h1C0; Dm_Wmem = 1'b0; Dm_Req = 1'b1;
    sb.push_back('{1'b1, mem_word(32'h1C0)});
    @(negedge Clk);
    @(negedge Clk);
    e = sb.pop_front();
    chk_cnt++;
    if (Dm_Ack !== 1'b1 || Dm_Rdata !== e.data)
      $display("FAIL mask_ack: got ack=%b rdata=%h want 1 rdata=%h", Dm_Ack, Dm_Rdata, e.data);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk_cnt++;
      if ({Mem_Cs, Dm_Ack, If_Ack} !== 3'b000)
        $display("FAIL mask_idle[%0d]: got cs/ackdm/ackif=%b want 000", i, {Mem_Cs, Dm_Ack, If_Ack});
      else pass_cnt++;
      Dm_Req = 1'b0;
    end
    chk_cnt++;
    if (sb.size() != 0) $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_wait();
    test_alternation();
    test_timeout();
    test_rst_mid();
    test_ack_mask();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish by 200000");
    $fatal(1);
  end

endmodule
